// File: rtl/hazard_flush_unit_if.sv
// Hazard/flush unit bundle.
// Carries the decode/execute-stage register addresses, execute-stage control
// bits and ALU flags into the hazard unit. It also carries the stall, flush,
// redirect and forwarding selects plus the event counters back out.
//   master : pipeline side; drives stage info, receives the controls
//   slave  : hazard unit side
interface hazard_flush_unit_if;
    logic [4:0]  Rs1D;
    logic [4:0]  Rs2D;
    logic [4:0]  Rs1E;
    logic [4:0]  Rs2E;
    logic [4:0]  RdE;
    logic        RegWriteE;
    logic        BranchE;
    logic        JumpE;
    logic [2:0]  ResultSrcE;
    logic [2:0]  funct3E;
    logic        ZeroE;
    logic        LtE;
    logic        LtuE;
    logic        StallF;
    logic        StallD;
    logic        FlushD;
    logic        FlushE;
    logic        PCSrcE;
    logic [1:0]  ForwardAE;
    logic [1:0]  ForwardBE;
    logic [15:0] StallCount;
    logic [15:0] FlushCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, BranchE, JumpE,
               ResultSrcE, funct3E, ZeroE, LtE, LtuE,
        input  StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RegWriteE, BranchE, JumpE,
               ResultSrcE, funct3E, ZeroE, LtE, LtuE,
        output StallF, StallD, FlushD, FlushE, PCSrcE, ForwardAE, ForwardBE,
               StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_flush_unit.sv
// Hazard detection, branch resolution and forwarding control for a 5-stage
// pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset; clears M/W tracking and counters
//   hz    : hazard_flush_unit_if.slave
//           inputs : stage register addresses, E-stage control bits, ALU flags
//           outputs: StallF/StallD/FlushD/FlushE/PCSrcE, ForwardAE/BE,
//                    StallCount/FlushCount (saturating)
// All control outputs are combinational. The only state is the M/W
// destination tracking and the two event counters.
module hazard_flush_unit (
    input logic              clk,
    input logic              reset,
    hazard_flush_unit_if.slave hz
);

    logic        rd_m_unused;
    logic [4:0]  rd_m_q, rd_m_d;
    logic        reg_write_m_q, reg_write_m_d;
    logic [4:0]  rd_w_q, rd_w_d;
    logic        reg_write_w_q, reg_write_w_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    logic taken;
    logic pc_src;
    logic lw_stall;
    logic stall;
    logic flush_e;

    assign rd_m_unused = 1'b0;

    always_comb begin
        taken = 1'b0;
        case (hz.funct3E)
            3'b000:  taken = hz.ZeroE;
            3'b001:  taken = ~hz.ZeroE;
            3'b100:  taken = hz.LtE;
            3'b101:  taken = ~hz.LtE;
            3'b110:  taken = hz.LtuE;
            3'b111:  taken = ~hz.LtuE;
            default: taken = 1'b0;
        endcase
    end

    assign pc_src   = hz.JumpE | (hz.BranchE & taken);
    assign lw_stall = (hz.ResultSrcE == 3'b001) && (hz.RdE != 5'd0) &&
                      ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D));
    // A redirect squashes the stalled instruction, so the stall is dropped.
    assign stall    = lw_stall & ~pc_src;
    assign flush_e  = pc_src | lw_stall;

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs) begin
            return 2'b10;
        end else if (wr_w && rd_w != 5'd0 && rd_w == rs) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign hz.StallF     = stall;
    assign hz.StallD     = stall;
    assign hz.FlushD     = pc_src;
    assign hz.FlushE     = flush_e;
    assign hz.PCSrcE     = pc_src;
    assign hz.ForwardAE  = fwd_sel(hz.Rs1E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    assign hz.ForwardBE  = fwd_sel(hz.Rs2E, rd_m_q, reg_write_m_q, rd_w_q, reg_write_w_q);
    assign hz.StallCount = stall_cnt_q;
    assign hz.FlushCount = flush_cnt_q;

    always_comb begin
        rd_m_d        = hz.RdE;
        reg_write_m_d = hz.RegWriteE;
        // A flushed E stage holds a bubble, so nothing valid moves into M.
        if (flush_e) begin
            rd_m_d        = 5'd0;
            reg_write_m_d = 1'b0;
        end
        rd_w_d        = rd_m_q;
        reg_write_w_d = reg_write_m_q;

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        flush_cnt_d = flush_cnt_q;
        if (pc_src && flush_cnt_q != 16'hFFFF) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_m_q        <= 5'd0;
            reg_write_m_q <= 1'b0;
            rd_w_q        <= 5'd0;
            reg_write_w_q <= 1'b0;
            stall_cnt_q   <= 16'd0;
            flush_cnt_q   <= 16'd0;
        end else begin
            rd_m_q        <= rd_m_d;
            reg_write_m_q <= reg_write_m_d;
            rd_w_q        <= rd_w_d;
            reg_write_w_q <= reg_write_w_d;
            stall_cnt_q   <= stall_cnt_d;
            flush_cnt_q   <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_flush_unit.sv
// Directed bench for hazard_flush_unit: a table of single-cycle control
// vectors, then hand-written sequences for load-use, forwarding priority,
// async reset and counter saturation.
module tb_hazard_flush_unit;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   m_stall = 0;
    int   m_flush = 0;

    hazard_flush_unit_if hz ();

    hazard_flush_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       br;
        logic       jmp;
        logic [2:0] f3;
        logic       z;
        logic       lt;
        logic       ltu;
        logic [2:0] src;
        logic [4:0] rde;
        logic [4:0] rs1d;
        logic [4:0] rs2d;
        logic       e_pc;
        logic       e_stall;
        logic       e_fe;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic br, logic jmp, logic [2:0] f3, logic z, logic lt,
                                logic ltu, logic [2:0] src, logic [4:0] rde,
                                logic [4:0] rs1d, logic [4:0] rs2d,
                                logic e_pc, logic e_stall, logic e_fe);
        vec_t v;
        v = '{br, jmp, f3, z, lt, ltu, src, rde, rs1d, rs2d, e_pc, e_stall, e_fe};
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        hz.Rs1D = 5'd0; hz.Rs2D = 5'd0; hz.Rs1E = 5'd0; hz.Rs2E = 5'd0; hz.RdE = 5'd0;
        hz.RegWriteE = 1'b0; hz.BranchE = 1'b0; hz.JumpE = 1'b0;
        hz.ResultSrcE = 3'd0; hz.funct3E = 3'd0;
        hz.ZeroE = 1'b0; hz.LtE = 1'b0; hz.LtuE = 1'b0;
    endtask

    // Advance one clock; the model counters follow the expected stall/redirect.
    task automatic tick(input logic st, input logic pc);
        if (st && m_stall < 65535) m_stall++;
        if (pc && m_flush < 65535) m_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string tag);
        check({tag, " stall_cnt"}, hz.StallCount, 16'(m_stall));
        check({tag, " flush_cnt"}, hz.FlushCount, 16'(m_flush));
    endtask

    initial begin
        vec_t v;
        reset = 1'b1;
        clear_inputs();

        vecs.push_back(mk(1, 0, 3'b000, 1, 0, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b000, 0, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b001, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b001, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b100, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b100, 1, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b101, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b101, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b110, 0, 0, 1, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b110, 0, 1, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b111, 0, 1, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b111, 0, 0, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b010, 1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 0, 3'b011, 1, 1, 1, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, 1, 0, 0, 3'b000, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3'b010, 0, 0, 0, 3'b000, 0, 0, 0, 1, 0, 1));
        // load-use on Rs1D / Rs2D, x0 and non-load cases
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b001, 5, 5, 0, 0, 1, 1));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b001, 5, 0, 5, 0, 1, 1));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b001, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b000, 5, 5, 5, 0, 0, 0));
        vecs.push_back(mk(0, 0, 3'b000, 0, 0, 0, 3'b011, 9, 9, 0, 0, 0, 0));
        // redirect overrides load-use
        vecs.push_back(mk(0, 1, 3'b000, 0, 0, 0, 3'b001, 5, 5, 0, 1, 0, 1));
        vecs.push_back(mk(1, 0, 3'b000, 1, 0, 0, 3'b001, 6, 0, 6, 1, 0, 1));

        // Reset state
        #2;
        check("rst fwdA", 16'(hz.ForwardAE), 16'd0);
        check("rst fwdB", 16'(hz.ForwardBE), 16'd0);
        check_counts("rst");
        #10;
        reset = 1'b0;
        tick(1'b0, 1'b0);
        check_counts("post-rst");

        // Table-driven single-cycle vectors
        for (int i = 0; i < vecs.size(); i++) begin
            string t;
            v = vecs[i];
            t = $sformatf("v%0d", i);
            clear_inputs();
            hz.BranchE = v.br; hz.JumpE = v.jmp; hz.funct3E = v.f3;
            hz.ZeroE = v.z; hz.LtE = v.lt; hz.LtuE = v.ltu;
            hz.ResultSrcE = v.src; hz.RdE = v.rde; hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d;
            #1;
            check({t, " PCSrcE"}, 16'(hz.PCSrcE), 16'(v.e_pc));
            check({t, " StallF"}, 16'(hz.StallF), 16'(v.e_stall));
            check({t, " StallD"}, 16'(hz.StallD), 16'(v.e_stall));
            check({t, " FlushD"}, 16'(hz.FlushD), 16'(v.e_pc));
            check({t, " FlushE"}, 16'(hz.FlushE), 16'(v.e_fe));
            check({t, " fwdA"}, 16'(hz.ForwardAE), 16'd0);
            tick(v.e_stall, v.e_pc);
            check_counts(t);
        end

        // Load-use with a writing load: the flushed E stage must not reach M
        clear_inputs();
        hz.RegWriteE = 1'b1; hz.ResultSrcE = 3'b001; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        #1;
        check("lu StallD", 16'(hz.StallD), 16'd1);
        check("lu FlushD", 16'(hz.FlushD), 16'd0);
        tick(1'b1, 1'b0);
        check_counts("lu");
        clear_inputs();
        hz.Rs1E = 5'd5;
        #1;
        check("lu no M fwd", 16'(hz.ForwardAE), 16'd0);
        tick(1'b0, 1'b0);

        // Forwarding priority: M over W, then W alone, then x0
        clear_inputs();
        hz.RegWriteE = 1'b1; hz.RdE = 5'd7;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        clear_inputs();
        hz.Rs1E = 5'd7; hz.Rs2E = 5'd7;
        #1;
        check("fwd A M", 16'(hz.ForwardAE), 16'b10);
        check("fwd B M", 16'(hz.ForwardBE), 16'b10);
        tick(1'b0, 1'b0);
        check("fwd A W", 16'(hz.ForwardAE), 16'b01);
        check("fwd B W", 16'(hz.ForwardBE), 16'b01);
        hz.Rs1E = 5'd0;
        #1;
        check("fwd A x0", 16'(hz.ForwardAE), 16'd0);
        tick(1'b0, 1'b0);
        check("fwd B drained", 16'(hz.ForwardBE), 16'd0);
        hz.RegWriteE = 1'b1; hz.RdE = 5'd0;
        tick(1'b0, 1'b0);
        clear_inputs();
        #1;
        check("fwd never x0", 16'(hz.ForwardAE), 16'd0);

        // Async reset mid-operation with valid M and W entries for x3
        hz.RegWriteE = 1'b1; hz.RdE = 5'd3;
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        clear_inputs();
        hz.Rs1E = 5'd3; hz.JumpE = 1'b1;
        #1;
        check("pre-rst fwdA", 16'(hz.ForwardAE), 16'b10);
        #1;
        reset = 1'b1;
        m_stall = 0;
        m_flush = 0;
        #1;
        check("arst fwdA", 16'(hz.ForwardAE), 16'd0);
        check("arst PCSrcE", 16'(hz.PCSrcE), 16'd1);
        check_counts("arst");
        @(posedge clk);
        #1;
        check_counts("arst held");
        reset = 1'b0;
        hz.JumpE = 1'b0;
        #1;
        check("post-arst fwdA", 16'(hz.ForwardAE), 16'd0);
        tick(1'b0, 1'b0);
        check("post-arst fwdA edge", 16'(hz.ForwardAE), 16'd0);

        // Flush counter saturation
        clear_inputs();
        hz.JumpE = 1'b1;
        for (int i = 0; i < 65540; i++) begin
            tick(1'b0, 1'b1);
        end
        check("sat flush", hz.FlushCount, 16'hFFFF);
        tick(1'b0, 1'b1);
        check("sat hold", hz.FlushCount, 16'hFFFF);
        check_counts("sat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_flush_unit.md
HAZARD_FLUSH_UNIT -- requirements
Module: hazard_flush_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL have ports Rs1D, Rs2D  input  5 each  decode-stage source register addresses.
REQ-004 SHALL have ports Rs1E, Rs2E, RdE  input  5 each  execute-stage source and destination addresses.
REQ-005 SHALL have ports RegWriteE, BranchE, JumpE  input  1 each  execute-stage control bits from the D->E control register.
REQ-006 SHALL have ports ResultSrcE  input  3 and funct3E  input  3  execute-stage result select and branch type.
REQ-007 SHALL have ports ZeroE, LtE, LtuE  input  1 each  ALU flags for equal, signed less-than, unsigned less-than.
REQ-008 SHALL have ports StallF, StallD, FlushD, FlushE, PCSrcE  output  1 each  pipeline hold, bubble and redirect controls.
REQ-009 SHALL have ports ForwardAE, ForwardBE  output  2 each  operand select: 00 register file, 10 M-stage result, 01 W-stage result.
REQ-010 SHALL have ports StallCount, FlushCount  output  16 each  saturating event counters.

Function
REQ-011 SHALL hold internal shadow registers RdM, RegWriteM, RdW, RegWriteW, updated every cycle: M <= E values, W <= M values.
REQ-012 SHALL load RdM=0 and RegWriteM=0 on a cycle in which FlushE is asserted, because the E stage holds a bubble.
REQ-013 SHALL decode branch condition from funct3E: 000 ZeroE; 001 !ZeroE; 100 LtE; 101 !LtE; 110 LtuE; 111 !LtuE; 010/011 not taken.
REQ-014 SHALL drive PCSrcE = JumpE | (BranchE & condition), combinational in the same cycle.
REQ-015 SHALL compute lwStall = (ResultSrcE==3'b001) & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-016 SHALL drive StallF = StallD = lwStall & !PCSrcE, so a redirect overrides a load-use stall.
REQ-017 SHALL drive FlushD = PCSrcE and FlushE = PCSrcE | lwStall.
REQ-018 SHALL select ForwardAE=10 when RegWriteM & RdM!=0 & RdM==Rs1E; else 01 when RegWriteW & RdW!=0 & RdW==Rs1E; else 00.
REQ-019 SHALL select ForwardBE by the same rule applied to Rs2E, with M taking priority over W.
REQ-020 SHALL never forward to or stall on register x0.
REQ-021 SHALL increment StallCount by 1 on each cycle with StallD=1 and FlushCount by 1 on each cycle with PCSrcE=1.
REQ-022 SHALL saturate each counter at 16'hFFFF, with no wrap to zero.
REQ-023 SHALL have zero added latency on all control outputs; the only sequential elements are the shadow registers and counters.

Reset
REQ-024 SHALL asynchronously clear RdM, RdW, RegWriteM, RegWriteW, StallCount and FlushCount to 0 while reset=1.
REQ-025 SHALL therefore drive ForwardAE=ForwardBE=00 throughout reset; stall, flush and PCSrcE outputs remain combinational functions of the current inputs.
REQ-026 SHALL, when reset is asserted mid-operation, discard all in-flight M/W tracking; the first cycle after reset performs no forwarding.

Verification
REQ-027 SHALL pass load-use: ResultSrcE=001, RdE=5, Rs1D=5, no branch -> StallF=StallD=FlushE=1, FlushD=0, StallCount +1; next cycle RdM=0, no M forward.
REQ-028 SHALL pass forwarding priority: RegWriteE=1 RdE=7, then next instruction RegWriteE=1 RdE=7, then Rs1E=7 -> ForwardAE=10; with the M entry cleared -> 01; Rs1E=0 -> 00.
REQ-029 SHALL pass branch table: BranchE=1 with each funct3 and flag combination -> PCSrcE per REQ-013; taken cases give FlushD=FlushE=1 and FlushCount +1.
REQ-030 SHALL pass simultaneous events: lwStall condition and JumpE=1 in the same cycle -> PCSrcE=1, FlushD=FlushE=1, StallF=StallD=0, FlushCount +1, StallCount unchanged.
REQ-031 SHALL pass saturation: force 65540 taken-jump cycles -> FlushCount reads 16'hFFFF and holds.
REQ-032 SHALL pass async reset: assert reset between clock edges while RegWriteM=1 RdM=3 and Rs1E=3 -> ForwardAE goes to 00 immediately and counters read 0.
